// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle-memory MIPS CPU: fetch FSM states,
// PC step size and opcode constants also used by the main decoder.
package cpu_pkg;

    typedef enum logic [1:0] {
        RESET_ST,
        FETCH,
        HOLD
    } fetch_state_t;

    localparam int unsigned PC_STEP = 4;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;

endpackage

// File: rtl/nextpc.sv
// Next-PC selection: jump target, PC-relative branch target or sequential PC.
// Purely combinational; the caller decides when the result is used.
module nextpc #(
    parameter int unsigned n = 32
) (
    input  logic [n-1:0] pcplus4,
    input  logic [25:0]  instr_index,
    input  logic [n-1:0] signimm,
    input  logic         pcsrc,
    input  logic         jump,
    output logic [n-1:0] next_pc
);

    // Jump wins over branch; branch offset is a word offset, so shift left by two
    // and let the top two bits of the immediate fall off.
    always_comb begin
        next_pc = pcplus4;
        if (jump) begin
            next_pc = {pcplus4[n-1:28], instr_index, 2'b00};
        end else if (pcsrc) begin
            next_pc = pcplus4 + {signimm[n-3:0], 2'b00};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one instruction at a time over
// a req/ready handshake, presents it until downstream advances, then moves the
// PC to the sequential, branch or jump target.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned    n        = 32,
    parameter logic [n-1:0]   RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [n-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic [31:0]  imem_rdata,
    output logic         instr_valid,
    output logic [31:0]  instr,
    output logic [5:0]   op,
    output logic [5:0]   funct,
    output logic [n-1:0] pc,
    output logic [n-1:0] pcplus4,
    input  logic         advance,
    input  logic         pcsrc,
    input  logic         jump,
    input  logic [n-1:0] signimm,
    output logic [31:0]  instr_count
);

    fetch_state_t state;
    logic [n-1:0] pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  count_q;
    logic         req_q;
    logic         valid_q;
    logic [n-1:0] next_pc;

    assign pcplus4 = pc_q + n'(PC_STEP);

    nextpc #(
        .n (n)
    ) u_nextpc (
        .pcplus4     (pcplus4),
        .instr_index (instr_q[25:0]),
        .signimm     (signimm),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .next_pc     (next_pc)
    );

    // Fetch FSM with its registered handshake outputs; reset clears req at once,
    // so a late imem_ready after reset has nothing to complete.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RESET_ST;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            count_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                RESET_ST: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        state   <= HOLD;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (advance) begin
                        pc_q    <= next_pc;
                        count_q <= count_q + 32'd1;
                        state   <= FETCH;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= RESET_ST;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign op          = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign pc          = pc_q;
    assign instr_count = count_q;

endmodule
